raw2rgb_bayer_pipe: RTL
=======================

Name: raw2rgb_bayer_pipe

Overview:
Parametrised streaming Bayer-to-RGB converter for the D8M camera path, sitting between the raw frame buffer read port and the VGA/RGB datapath. It generalises the fixed 10-bit RGGB converter in four ways:
- configurable pixel and output widths, line length and valid window;
- run-time selection of all four Bayer phases;
- an internal one-line buffer with its own pixel/line counters;
- an aligned output-valid strobe with fixed latency.

Parameters:
DATA_W, 10, raw pixel width
OUT_W, 8, output colour channel width
LINE_LEN, 640, pixels per line (line buffer depth)
CNT_W, 11, width of X/Y counters
X_MIN, 3, output valid only when X > X_MIN
X_MAX, 637, output valid only when X < X_MAX

Ports:
VGA_CLK  in  1  single clock, rising edge
RESET_N  in  1  asynchronous active-low reset
iFVAL  in  1  frame valid, active-high; low clears counters
iDVAL  in  1  pixel strobe; iDATA accepted when high
iDATA  in  DATA_W  raw Bayer pixel
iPATTERN  in  2  0=RGGB, 1=GRBG, 2=GBRG, 3=BGGR
oRed  out  OUT_W  red channel
oGreen  out  OUT_W  green channel
oBlue  out  OUT_W  blue channel
oDVAL  out  1  output pixel valid
oX  out  CNT_W  column of output pixel
oY  out  CNT_W  row of output pixel

Behaviour:
- Reset (RESET_N low, asynchronous): all outputs, counters, pipeline registers and valid flags go to 0. Line RAM contents are not reset.
- Counters:
  - X increments on each accepted pixel. At X = LINE_LEN-1 with iDVAL high, X wraps to 0 and Y increments.
  - Y wraps naturally at 2^CNT_W.
  - iFVAL low: X, Y and all stage valid flags are cleared on the next edge. This takes priority over iDVAL.
- Pattern latch: iPATTERN is sampled every cycle iFVAL is low and held constant while iFVAL is high. A mid-frame change has no effect until the next frame.
- Line buffer (sub-module): LINE_LEN x DATA_W simple dual-port RAM with synchronous read.
  - Cycle N with iDVAL high: read address X and write iDATA to address X.
  - Read-during-write to the same address returns old data (previous line).
- Pipeline, fixed 3-cycle latency:
  - S1 (edge ending cycle N): register iDATA as cur, plus X, Y and valid.
  - S2, only when the S1 valid is set: T <= RAM output, D <= cur, A <= T, C <= D. This forms the 2x2 window A=(x-1,y-1), T=(x,y-1), C=(x-1,y), D=(x,y).
  - S3, every cycle: compute colour, register outputs, oX/oY, oDVAL.
  - Stalls (iDVAL low) freeze S2; S1/S3 valids drop to 0 for those cycles.
- Phase selection: px = x[0]^pat[0], py = y[0]^pat[1].
  - (0,0): R=D, B=A, G=(T+C)>>1
  - (1,1): R=A, B=D, G=(T+C)>>1
  - (1,0): R=C, B=T, G=(A+D)>>1
  - (0,1): R=T, B=C, G=(A+D)>>1
- Width rules:
  - G sum is formed at DATA_W+1 bits and truncated by the shift.
  - If OUT_W <= DATA_W, each channel is its top OUT_W bits.
  - Otherwise the channel is left-aligned and zero-filled.
- Window gating: oDVAL = S2 valid AND X_MIN < x < X_MAX AND y >= 1. When oDVAL would be 0, oRed/oGreen/oBlue are forced to 0; oX/oY still track.

Decomposition:
- Shared package: Bayer pattern codes (RGGB/GRBG/GBRG/BGGR), default D8M line constants (640, 3, 637), and the phase-to-colour select enum.
- One sub-module, bayer_line_ram: parametrised RAM with old-data read-during-write. It is the only inferred memory.

Test Plan:
- RGGB flat frame, R pixels 0x3FC, G 0x200, B 0x100, 4 lines of 640 → every valid pixel gives oRed=0xFF, oGreen=0x80, oBlue=0x40, with oDVAL set.
- Same raw data with iPATTERN=3 latched before frame → oRed=0x40, oBlue=0xFF, oGreen=0x80. A change to iPATTERN mid-frame has no effect until iFVAL cycles low.
- Gapped stream, iDVAL pattern 1,0,0,1,1,0 → oDVAL pulses exactly 3 cycles after each accepted pixel and its colour matches the ungapped run.
- Boundaries:
  - row 0, and x ≤ 3 or x ≥ 637 → oDVAL=0 and RGB=0;
  - pixel at X=639 → X wraps to 0 and Y=1 on the next accept.
- RESET_N asserted mid-line between clock edges → all outputs 0 immediately. After release, the first accepted pixel has X=0, Y=0.
- iFVAL dropped at X=200, Y=5 → X=Y=0 on the next edge, and oDVAL=0 from cycle +1 onward with no spurious pulse.

Source files
------------

// File: rtl/raw2rgb_bayer_pipe_pkg.sv
// raw2rgb_bayer_pipe_pkg: Bayer pattern codes, D8M line defaults and the
// phase-to-colour select shared by the Bayer converter.
package raw2rgb_bayer_pipe_pkg;

   typedef enum logic [1:0] {
      PAT_RGGB = 2'd0,
      PAT_GRBG = 2'd1,
      PAT_GBRG = 2'd2,
      PAT_BGGR = 2'd3
   } bayer_pat_e;

   localparam int D8M_LINE_LEN = 640;
   localparam int D8M_X_MIN    = 3;
   localparam int D8M_X_MAX    = 637;

   // Encoded as {py, px}; names which raw pixel of the 2x2 window holds which colour
   typedef enum logic [1:0] {
      PH_R_AT_D = 2'b00,
      PH_GR_ROW = 2'b01,
      PH_GB_ROW = 2'b10,
      PH_B_AT_D = 2'b11
   } phase_e;

   function automatic phase_e phase_sel(input logic px, input logic py);
      return phase_e'({py, px});
   endfunction

endpackage

// File: rtl/raw2rgb_bayer_pipe_ram.sv
// bayer_line_ram: one-line simple dual-port RAM, synchronous read,
// read-during-write to the same address returns the previous line's pixel.
module bayer_line_ram #(
   parameter int DEPTH = 640,
   parameter int W     = 10,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          en,
   input  logic [AW-1:0] addr,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];
   logic [W-1:0] rd_q;

   always_ff @(posedge clk) begin
      if (en) begin
         rd_q       <= mem[addr];
         mem[addr]  <= wdata;
      end
   end

   assign rdata = rd_q;

endmodule

// File: rtl/raw2rgb_bayer_pipe.sv
// raw2rgb_bayer_pipe: streaming Bayer-to-RGB converter with a one-line buffer,
// run-time Bayer phase selection and a fixed 3-cycle aligned output strobe.
module raw2rgb_bayer_pipe
   import raw2rgb_bayer_pipe_pkg::*;
#(
   parameter int DATA_W   = 10,
   parameter int OUT_W    = 8,
   parameter int LINE_LEN = D8M_LINE_LEN,
   parameter int CNT_W    = 11,
   parameter int X_MIN    = D8M_X_MIN,
   parameter int X_MAX    = D8M_X_MAX
) (
   input  logic              VGA_CLK,
   input  logic              RESET_N,
   input  logic              iFVAL,
   input  logic              iDVAL,
   input  logic [DATA_W-1:0] iDATA,
   input  logic [1:0]        iPATTERN,
   output logic [OUT_W-1:0]  oRed,
   output logic [OUT_W-1:0]  oGreen,
   output logic [OUT_W-1:0]  oBlue,
   output logic              oDVAL,
   output logic [CNT_W-1:0]  oX,
   output logic [CNT_W-1:0]  oY
);

   localparam int AW = $clog2(LINE_LEN);

   logic              acc, line_end, win;
   logic [DATA_W-1:0] ram_rd;
   logic [CNT_W-1:0]  x_q, x_d, y_q, y_d;
   bayer_pat_e        pat_q, pat_d;
   logic [DATA_W-1:0] cur_q, cur_d;
   logic [CNT_W-1:0]  x1_q, x1_d, y1_q, y1_d;
   logic              v1_q, v1_d;
   logic [DATA_W-1:0] t_q, t_d, d_q, d_d, a_q, a_d, c_q, c_d;
   logic [CNT_W-1:0]  x2_q, x2_d, y2_q, y2_d;
   logic              v2_q, v2_d;
   logic [OUT_W-1:0]  red_q, red_d, grn_q, grn_d, blu_q, blu_d;
   logic [CNT_W-1:0]  ox_q, ox_d, oy_q, oy_d;
   logic              ov_q, ov_d;
   logic [DATA_W:0]   g_tc, g_ad;
   logic [DATA_W-1:0] r_raw, g_raw, b_raw;
   phase_e            ph;

   // Channels are the top OUT_W bits, or the pixel left-aligned with zero fill when wider
   function automatic logic [OUT_W-1:0] fit(input logic [DATA_W-1:0] v);
      logic [DATA_W+OUT_W-1:0] w;
      w = {v, {OUT_W{1'b0}}};
      return w[DATA_W+OUT_W-1 -: OUT_W];
   endfunction

   assign acc      = iFVAL & iDVAL;
   assign line_end = x_q == CNT_W'(LINE_LEN - 1);

   bayer_line_ram #(.DEPTH(LINE_LEN), .W(DATA_W), .AW(AW)) u_ram (
      .clk   (VGA_CLK),
      .en    (acc),
      .addr  (x_q[AW-1:0]),
      .wdata (iDATA),
      .rdata (ram_rd)
   );

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (!iFVAL) begin
         x_d = '0;
         y_d = '0;
      end else if (iDVAL) begin
         x_d = line_end ? '0 : x_q + CNT_W'(1);
         y_d = line_end ? y_q + CNT_W'(1) : y_q;
      end
      pat_d = iFVAL ? pat_q : bayer_pat_e'(iPATTERN);
   end

   always_comb begin
      cur_d = iDATA;
      x1_d  = x_q;
      y1_d  = y_q;
      v1_d  = acc;
      t_d   = v1_q ? ram_rd : t_q;
      d_d   = v1_q ? cur_q : d_q;
      a_d   = v1_q ? t_q : a_q;
      c_d   = v1_q ? d_q : c_q;
      x2_d  = v1_q ? x1_q : x2_q;
      y2_d  = v1_q ? y1_q : y2_q;
      v2_d  = iFVAL & v1_q;
   end

   always_comb begin
      g_tc  = {1'b0, t_q} + {1'b0, c_q};
      g_ad  = {1'b0, a_q} + {1'b0, d_q};
      ph    = phase_sel(x2_q[0] ^ pat_q[0], y2_q[0] ^ pat_q[1]);
      r_raw = ph == PH_R_AT_D ? d_q : ph == PH_B_AT_D ? a_q : ph == PH_GR_ROW ? c_q : t_q;
      b_raw = ph == PH_R_AT_D ? a_q : ph == PH_B_AT_D ? d_q : ph == PH_GR_ROW ? t_q : c_q;
      g_raw = (ph == PH_R_AT_D || ph == PH_B_AT_D) ? g_tc[DATA_W:1] : g_ad[DATA_W:1];
      win   = v2_q && x2_q > CNT_W'(X_MIN) && x2_q < CNT_W'(X_MAX) && y2_q != '0;
      ov_d  = iFVAL & win;
      red_d = ov_d ? fit(r_raw) : '0;
      grn_d = ov_d ? fit(g_raw) : '0;
      blu_d = ov_d ? fit(b_raw) : '0;
      ox_d  = x2_q;
      oy_d  = y2_q;
   end

   always_ff @(posedge VGA_CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         x_q   <= '0;
         y_q   <= '0;
         pat_q <= PAT_RGGB;
         cur_q <= '0;
         x1_q  <= '0;
         y1_q  <= '0;
         v1_q  <= 1'b0;
         t_q   <= '0;
         d_q   <= '0;
         a_q   <= '0;
         c_q   <= '0;
         x2_q  <= '0;
         y2_q  <= '0;
         v2_q  <= 1'b0;
         red_q <= '0;
         grn_q <= '0;
         blu_q <= '0;
         ox_q  <= '0;
         oy_q  <= '0;
         ov_q  <= 1'b0;
      end else begin
         x_q   <= x_d;
         y_q   <= y_d;
         pat_q <= pat_d;
         cur_q <= cur_d;
         x1_q  <= x1_d;
         y1_q  <= y1_d;
         v1_q  <= v1_d;
         t_q   <= t_d;
         d_q   <= d_d;
         a_q   <= a_d;
         c_q   <= c_d;
         x2_q  <= x2_d;
         y2_q  <= y2_d;
         v2_q  <= v2_d;
         red_q <= red_d;
         grn_q <= grn_d;
         blu_q <= blu_d;
         ox_q  <= ox_d;
         oy_q  <= oy_d;
         ov_q  <= ov_d;
      end
   end

   assign oRed   = red_q;
   assign oGreen = grn_q;
   assign oBlue  = blu_q;
   assign oDVAL  = ov_q;
   assign oX     = ox_q;
   assign oY     = oy_q;

endmodule
